// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one load/store at a time onto the io_lsu bus, with lane steering and a response timeout.
// Optional LSU_MISALIGN_SPLIT_EN: beat-crossing misaligned accesses run as two bus beats instead of erroring.
module lsu_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              io_lsu_reqValid,
  output logic [XLEN-1:0]   io_lsu_addr,
  output logic [1:0]        io_lsu_size,
  output logic              io_lsu_wen,
  output logic [XLEN-1:0]   io_lsu_wdata,
  output logic [XLEN/8-1:0] io_lsu_wmask,
  input  logic              io_lsu_respValid,
  input  logic [XLEN-1:0]   io_lsu_rdata
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LB-1:0]   off_q;
  logic [1:0]      size_q;
  logic            wen_q;
  logic            signed_q;

  // Request decode on the live inputs, used only in the accept cycle
  logic [LB-1:0]   req_off_c;
  logic [2:0]      amask_c;
  logic [7:0]      size_bytes_c;
  logic            illegal_c;
  logic            misal_c;
  logic            bad_c;
  logic [XLEN-1:0] lane_wdata_c;
  logic [NB-1:0]   lane_wmask_c;
  logic            more_beats_c;

  assign req_off_c = req_addr[LB-1:0];
  assign amask_c   = 3'((4'd1 << req_size) - 4'd1);
  assign misal_c   = |(req_addr[2:0] & amask_c);
  assign illegal_c = 32'(req_size) > LB;

  always_comb begin
    size_bytes_c = 8'h01;
    case (req_size)
      2'd0:    size_bytes_c = 8'h01;
      2'd1:    size_bytes_c = 8'h03;
      2'd2:    size_bytes_c = 8'h0F;
      default: size_bytes_c = 8'hFF;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic            split_q;
  logic            second_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] hi_wdata_q;
  logic [NB-1:0]   hi_wmask_q;
  logic            cross_c;
  logic [2*XLEN-1:0] wide_wdata_c;
  logic [2*NB-1:0]   wide_wmask_c;

  assign cross_c      = (32'(req_off_c) + (32'd1 << req_size)) > NB;
  assign bad_c        = illegal_c;
  assign wide_wdata_c = {XLEN'(0), req_wdata} << {req_off_c, 3'b000};
  assign wide_wmask_c = (2*NB)'(16'(size_bytes_c) << req_off_c);
  assign lane_wdata_c = wide_wdata_c[XLEN-1:0];
  assign lane_wmask_c = wide_wmask_c[NB-1:0];
  assign more_beats_c = split_q && !second_q;
`else
  assign bad_c        = illegal_c | misal_c;
  assign lane_wdata_c = req_wdata << {req_off_c, 3'b000};
  assign lane_wmask_c = NB'(16'(size_bytes_c) << req_off_c);
  assign more_beats_c = 1'b0;
`endif

  // Load extraction: shift the selected bytes down, then extend from the access width
  logic [XLEN-1:0] rd_shift_c;
  logic [XLEN-1:0] hi_mask_c;
  logic            sign_c;
  logic [XLEN-1:0] load_c;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign rd_shift_c = XLEN'({second_q ? io_lsu_rdata : XLEN'(0),
                             second_q ? lo_q : io_lsu_rdata} >> {off_q, 3'b000});
`else
  assign rd_shift_c = io_lsu_rdata >> {off_q, 3'b000};
`endif
  assign hi_mask_c = {XLEN{1'b1}} << (7'd8 << size_q);

  always_comb begin
    sign_c = 1'b0;
    case (size_q)
      2'd0:    sign_c = rd_shift_c[7];
      2'd1:    sign_c = rd_shift_c[15];
      2'd2:    sign_c = rd_shift_c[31];
      default: sign_c = rd_shift_c[XLEN-1];
    endcase
    load_c = (rd_shift_c & ~hi_mask_c) | ((signed_q && sign_c) ? hi_mask_c : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      off_q           <= '0;
      size_q          <= '0;
      wen_q           <= 1'b0;
      signed_q        <= 1'b0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      io_lsu_reqValid <= 1'b0;
      io_lsu_addr     <= '0;
      io_lsu_size     <= '0;
      io_lsu_wen      <= 1'b0;
      io_lsu_wdata    <= '0;
      io_lsu_wmask    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q         <= 1'b0;
      second_q        <= 1'b0;
      lo_q            <= '0;
      hi_wdata_q      <= '0;
      hi_wmask_q      <= '0;
`endif
    end else begin
      io_lsu_reqValid <= 1'b0;
      resp_valid      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_off_c;
            size_q    <= req_size;
            wen_q     <= req_wen;
            signed_q  <= req_signed;
            if (bad_c) begin
              state      <= S_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state           <= S_REQ;
              io_lsu_reqValid <= 1'b1;
              io_lsu_addr     <= {req_addr[XLEN-1:LB], LB'(0)};
              io_lsu_size     <= 2'(LB);
              io_lsu_wen      <= req_wen;
              io_lsu_wdata    <= req_wen ? lane_wdata_c : '0;
              io_lsu_wmask    <= req_wen ? lane_wmask_c : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_q    <= cross_c;
              second_q   <= 1'b0;
              hi_wdata_q <= req_wen ? wide_wdata_c[2*XLEN-1:XLEN] : '0;
              hi_wmask_q <= req_wen ? wide_wmask_c[2*NB-1:NB] : '0;
`endif
            end
          end
        end
        // A response in the REQ cycle itself is taken (zero-wait bus)
        S_REQ, S_WAIT: begin
          if (io_lsu_respValid) begin
            cnt <= '0;
            if (more_beats_c) begin
`ifdef LSU_MISALIGN_SPLIT_EN
              state           <= S_REQ;
              second_q        <= 1'b1;
              lo_q            <= io_lsu_rdata;
              io_lsu_reqValid <= 1'b1;
              io_lsu_addr     <= io_lsu_addr + XLEN'(NB);
              io_lsu_wdata    <= hi_wdata_q;
              io_lsu_wmask    <= hi_wmask_q;
`endif
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= wen_q ? '0 : load_c;
            end
          end else if ((state == S_WAIT) && (TIMEOUT != 0) && (cnt == TO_LAST)) begin
            cnt        <= '0;
            state      <= S_ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            if (state == S_WAIT) cnt <= cnt + CW'(1);
            state <= S_WAIT;
          end
        end
        S_RESP, S_ERR: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          second_q   <= 1'b0;
          split_q    <= 1'b0;
`endif
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl (XLEN=32, TIMEOUT=4) with hand-computed expectations.
module tb_lsu_ctrl;
  localparam int unsigned XLEN = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        io_lsu_reqValid;
  logic [31:0] io_lsu_addr;
  logic [1:0]  io_lsu_size;
  logic        io_lsu_wen;
  logic [31:0] io_lsu_wdata;
  logic [3:0]  io_lsu_wmask;
  logic        io_lsu_respValid = 1'b0;
  logic [31:0] io_lsu_rdata = '0;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_addr(io_lsu_addr),
    .io_lsu_size(io_lsu_size), .io_lsu_wen(io_lsu_wen), .io_lsu_wdata(io_lsu_wdata),
    .io_lsu_wmask(io_lsu_wmask), .io_lsu_respValid(io_lsu_respValid),
    .io_lsu_rdata(io_lsu_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  // One-wait-cycle load: REQ, WAIT (response arrives), RESP, IDLE
  task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, size, sgn, addr, 32'hDEAD_BEEF);
    check({tag, "_reqvalid"}, 64'(io_lsu_reqValid), 64'd1);
    check({tag, "_busaddr"}, 64'(io_lsu_addr), 64'({addr[31:2], 2'b00}));
    check({tag, "_wmask"}, 64'(io_lsu_wmask), 64'd0);
    step();
    check({tag, "_reqpulse"}, 64'(io_lsu_reqValid), 64'd0);
    check({tag, "_addrhold"}, 64'(io_lsu_addr), 64'({addr[31:2], 2'b00}));
    io_lsu_respValid = 1'b1; io_lsu_rdata = rd;
    step();
    io_lsu_respValid = 1'b0; io_lsu_rdata = '0;
    check({tag, "_respvalid"}, 64'(resp_valid), 64'd1);
    check({tag, "_rdata"}, 64'(resp_rdata), 64'(exp));
    check({tag, "_err"}, 64'(resp_err), 64'd0);
    step();
    check({tag, "_resppulse"}, 64'(resp_valid), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  // Zero-wait store: response arrives in the REQ cycle
  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    issue(1'b1, size, 1'b0, addr, wd);
    check({tag, "_reqvalid"}, 64'(io_lsu_reqValid), 64'd1);
    check({tag, "_wen"}, 64'(io_lsu_wen), 64'd1);
    check({tag, "_wmask"}, 64'(io_lsu_wmask), 64'(exp_mask));
    check({tag, "_wdata"}, 64'(io_lsu_wdata), 64'(exp_wd));
    check({tag, "_busaddr"}, 64'(io_lsu_addr), 64'({addr[31:2], 2'b00}));
    io_lsu_respValid = 1'b1;
    step();
    io_lsu_respValid = 1'b0;
    check({tag, "_respvalid"}, 64'(resp_valid), 64'd1);
    check({tag, "_reqpulse"}, 64'(io_lsu_reqValid), 64'd0);
    check({tag, "_rdata"}, 64'(resp_rdata), 64'd0);
    check({tag, "_err"}, 64'(resp_err), 64'd0);
    step();
    check({tag, "_resppulse"}, 64'(resp_valid), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
    issue(1'b0, size, 1'b0, addr, '0);
    check({tag, "_respvalid"}, 64'(resp_valid), 64'd1);
    check({tag, "_err"}, 64'(resp_err), 64'd1);
    check({tag, "_rdata"}, 64'(resp_rdata), 64'd0);
    check({tag, "_noreq"}, 64'(io_lsu_reqValid), 64'd0);
    step();
    check({tag, "_resppulse"}, 64'(resp_valid), 64'd0);
    check({tag, "_errclr"}, 64'(resp_err), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    // Reset values
    step();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_respvalid", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_reqvalid", 64'(io_lsu_reqValid), 64'd0);
    check("rst_addr", 64'(io_lsu_addr), 64'd0);
    check("rst_size", 64'(io_lsu_size), 64'd0);
    check("rst_wen", 64'(io_lsu_wen), 64'd0);
    check("rst_wdata", 64'(io_lsu_wdata), 64'd0);
    check("rst_wmask", 64'(io_lsu_wmask), 64'd0);
    reset = 1'b1;
    step();

    // Loads: byte lane 3 signed, halfword unsigned/signed, word ignores signed
    do_load("lb_s", 2'd0, 1'b1, 32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    check("bus_size", 64'(io_lsu_size), 64'd2);
    do_load("lbu", 2'd0, 1'b0, 32'h0000_1001, 32'h80AA_BBCC, 32'h0000_00BB);
    do_load("lhu", 2'd1, 1'b0, 32'h0000_6002, 32'h8765_4321, 32'h0000_8765);
    do_load("lh_s", 2'd1, 1'b1, 32'h0000_6000, 32'h1234_F00D, 32'hFFFF_F00D);
    do_load("lw_s", 2'd2, 1'b1, 32'h0000_7000, 32'h8000_0001, 32'h8000_0001);

    // Stores: lane steering and masks
    do_store("sh", 2'd1, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000);
    do_store("sb", 2'd0, 32'h0000_8001, 32'h0000_00EF, 4'b0010, 32'h0000_EF00);
    do_store("sw", 2'd2, 32'h0000_8004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Illegal size on a 32-bit unit
    expect_err("ld_illegal", 2'd3, 32'h0000_4000);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Beat-crossing lw: two beats concatenated before extraction
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3001, '0);
    check("split_b0_req", 64'(io_lsu_reqValid), 64'd1);
    check("split_b0_addr", 64'(io_lsu_addr), 64'h3000);
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h4433_2211;
    step();
    check("split_b1_req", 64'(io_lsu_reqValid), 64'd1);
    check("split_b1_addr", 64'(io_lsu_addr), 64'h3004);
    check("split_b0_noresp", 64'(resp_valid), 64'd0);
    io_lsu_rdata = 32'h8877_6655;
    step();
    io_lsu_respValid = 1'b0;
    check("split_respvalid", 64'(resp_valid), 64'd1);
    check("split_rdata", 64'(resp_rdata), 64'h5544_3322);
    check("split_err", 64'(resp_err), 64'd0);
    step();
`else
    // Misaligned lw errors without a bus beat
    expect_err("lw_misal", 2'd2, 32'h0000_3001);
    expect_err("lh_misal", 2'd1, 32'h0000_3003);
`endif

    // Timeout with TIMEOUT=4: error one cycle after the 4th WAIT cycle
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, '0);
    check("to_reqvalid", 64'(io_lsu_reqValid), 64'd1);
    for (int i = 0; i < 4; i++) step();
    check("to_wait4_noresp", 64'(resp_valid), 64'd0);
    check("to_wait4_busy", 64'(req_ready), 64'd0);
    step();
    check("to_respvalid", 64'(resp_valid), 64'd1);
    check("to_err", 64'(resp_err), 64'd1);
    check("to_rdata", 64'(resp_rdata), 64'd0);
    step();
    check("to_ready", 64'(req_ready), 64'd1);
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h1111_1111;
    step();
    io_lsu_respValid = 1'b0;
    check("to_late_ignored", 64'(resp_valid), 64'd0);
    check("to_late_ready", 64'(req_ready), 64'd1);

    // Reset asserted mid-WAIT clears outputs immediately
    issue(1'b0, 2'd2, 1'b0, 32'h0000_9004, '0);
    step();
    check("rw_inwait", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("rw_addr", 64'(io_lsu_addr), 64'd0);
    check("rw_size", 64'(io_lsu_size), 64'd0);
    check("rw_reqvalid", 64'(io_lsu_reqValid), 64'd0);
    check("rw_respvalid", 64'(resp_valid), 64'd0);
    check("rw_ready", 64'(req_ready), 64'd1);
    io_lsu_respValid = 1'b1; io_lsu_rdata = 32'h2222_2222;
    #2;
    reset = 1'b1;
    step();
    check("rw_stale_ignored", 64'(resp_valid), 64'd0);
    check("rw_stale_ready", 64'(req_ready), 64'd1);
    io_lsu_respValid = 1'b0; io_lsu_rdata = '0;
    do_load("rw_after", 2'd1, 1'b1, 32'h0000_A002, 32'h7FFF_0000, 32'h0000_7FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
